// File: rtl/mcu0_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification helpers
// for the mcu0 accumulator core.
package mcu0_pkg;

  typedef enum logic [2:0] {
    S_FETCH_REQ = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_MEM       = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h4;
  localparam logic [3:0] OP_JEQ = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_JLT = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_OR  = 4'hA;
  localparam logic [3:0] OP_XOR = 4'hB;
  localparam logic [3:0] OP_SHL = 4'hC;
  localparam logic [3:0] OP_SHR = 4'hD;
  localparam logic [3:0] OP_NOP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Opcodes that need a memory transaction at address C before completing.
  function automatic logic is_mem_op(input logic [3:0] op);
    return op inside {OP_LD, OP_ADD, OP_ST, OP_CMP, OP_SUB, OP_AND, OP_OR, OP_XOR};
  endfunction

  function automatic logic writes_a(input logic [3:0] op);
    return op inside {OP_LD, OP_ADD, OP_SUB, OP_LDI, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
  endfunction

endpackage

// File: rtl/mcu0_if.sv
// Request/ready memory bus between the mcu0 core (master) and its memory (slave).
interface mcu0_if #(
  parameter int DW = 16,
  parameter int AW = 12
) ();
  logic          men;
  logic          mw;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic [DW-1:0] mrdata;
  logic          mready;

  modport master (output men, mw, maddr, mwdata, input mrdata, mready);
  modport slave  (input men, mw, maddr, mwdata, output mrdata, mready);
endinterface

// File: rtl/mcu0_alu.sv
// Combinational ALU: computes the new accumulator value and N/Z/CY for one opcode.
module mcu0_alu
  import mcu0_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] m,
  input  logic          cy_in,
  output logic [DW-1:0] result,
  output logic          n,
  output logic          z,
  output logic          cy
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  assign sum  = {1'b0, a} + {1'b0, m};
  assign diff = {1'b0, a} - {1'b0, m};

  always_comb begin
    result = a;
    cy     = cy_in;
    case (op)
      OP_LD, OP_LDI: result = m;
      OP_ADD: begin result = sum[DW-1:0];  cy = sum[DW];  end
      OP_SUB: begin result = diff[DW-1:0]; cy = diff[DW]; end
      OP_AND: result = a & m;
      OP_OR:  result = a | m;
      OP_XOR: result = a ^ m;
      OP_SHL: begin result = {a[DW-2:0], 1'b0}; cy = a[DW-1]; end
      OP_SHR: begin result = {1'b0, a[DW-1:1]}; cy = a[0];    end
      default: ;
    endcase
    // CMP reports the unsigned relation of A and M; every other op reports on the result.
    if (op == OP_CMP) begin
      n = (a < m);
      z = (a == m);
    end else begin
      n = result[DW-1];
      z = (result == '0);
    end
  end

endmodule

// File: rtl/mcu0_core.sv
// mcu0 accumulator core: fetch/decode/memory FSM driving a request/ready bus
// with arbitrary wait states; all outputs come straight from registers.
module mcu0_core
  import mcu0_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 12,
  parameter int INC    = 2,
  parameter int RST_PC = 0
) (
  input  logic          clock,
  input  logic          reset,
  mcu0_if.master        mbus,
  output logic          halted,
  output logic [AW-1:0] dbg_pc,
  output logic [DW-1:0] dbg_a,
  output logic [DW-1:0] dbg_sw
);

  localparam int FLAG_N  = DW - 1;
  localparam int FLAG_Z  = DW - 2;
  localparam int FLAG_CY = DW - 3;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n, maddr, maddr_n;
  logic [DW-1:0] a, a_n, sw, sw_n, ir, ir_n, mwdata, mwdata_n;
  logic          men, men_n, mw, mw_n, halt, halt_n;

  logic [3:0]    op;
  logic [DW-1:0] imm;
  logic [AW-1:0] c_addr;
  logic          accept;
  logic          do_exec;
  logic [DW-1:0] alu_m, alu_res;
  logic          alu_n, alu_z, alu_cy;

  assign op     = ir[DW-1:DW-4];
  assign imm    = {4'b0000, ir[DW-5:0]};
  assign c_addr = ir[AW-1:0];
  assign accept = men && mbus.mready;
  // Memory operand during S_MEM; otherwise the zero-extended constant field (LDI).
  assign alu_m  = (state == S_MEM) ? mbus.mrdata : imm;

  mcu0_alu #(.DW(DW)) u_alu (
    .op     (op),
    .a      (a),
    .m      (alu_m),
    .cy_in  (sw[FLAG_CY]),
    .result (alu_res),
    .n      (alu_n),
    .z      (alu_z),
    .cy     (alu_cy)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH_REQ;
      pc     <= AW'(RST_PC);
      a      <= '0;
      sw     <= '0;
      ir     <= '0;
      men    <= 1'b0;
      mw     <= 1'b0;
      maddr  <= '0;
      mwdata <= '0;
      halt   <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      a      <= a_n;
      sw     <= sw_n;
      ir     <= ir_n;
      men    <= men_n;
      mw     <= mw_n;
      maddr  <= maddr_n;
      mwdata <= mwdata_n;
      halt   <= halt_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    a_n      = a;
    sw_n     = sw;
    ir_n     = ir;
    men_n    = men;
    mw_n     = mw;
    maddr_n  = maddr;
    mwdata_n = mwdata;
    halt_n   = halt;
    do_exec  = 1'b0;

    case (state)
      S_FETCH_REQ: begin
        men_n   = 1'b1;
        mw_n    = 1'b0;
        maddr_n = pc;
        state_n = S_FETCH;
      end
      S_FETCH: begin
        if (accept) begin
          ir_n    = mbus.mrdata;
          pc_n    = pc + AW'(INC);
          men_n   = 1'b0;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        state_n = S_FETCH_REQ;
        if (is_mem_op(op)) begin
          men_n   = 1'b1;
          mw_n    = (op == OP_ST);
          maddr_n = c_addr;
          if (op == OP_ST) mwdata_n = a;
          state_n = S_MEM;
        end else begin
          case (op)
            OP_JMP: pc_n = c_addr;
            OP_JEQ: if (sw[FLAG_Z]) pc_n = c_addr;
            OP_JLT: if (sw[FLAG_N]) pc_n = c_addr;
            OP_HLT: begin
              state_n = S_HALT;
              halt_n  = 1'b1;
            end
            default: do_exec = writes_a(op);
          endcase
        end
      end
      S_MEM: begin
        if (accept) begin
          men_n   = 1'b0;
          mw_n    = 1'b0;
          do_exec = (op != OP_ST);
          state_n = S_FETCH_REQ;
        end
      end
      S_HALT: begin
        men_n  = 1'b0;
        halt_n = 1'b1;
      end
      default: state_n = S_FETCH_REQ;
    endcase

    // Non-flag SW bits always read zero; CY passes through the ALU unchanged where it must not move.
    if (do_exec) begin
      if (writes_a(op)) a_n = alu_res;
      sw_n          = '0;
      sw_n[FLAG_N]  = alu_n;
      sw_n[FLAG_Z]  = alu_z;
      sw_n[FLAG_CY] = alu_cy;
    end
  end

  assign mbus.men    = men;
  assign mbus.mw     = mw;
  assign mbus.maddr  = maddr;
  assign mbus.mwdata = mwdata;
  assign halted      = halt;
  assign dbg_pc      = pc;
  assign dbg_a       = a;
  assign dbg_sw      = sw;

endmodule

// File: tb/tb_mcu0_core.sv
// Directed bench for mcu0_core with a behavioural zero/multi-wait memory.
module tb_mcu0_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        halted;
  logic [11:0] dbg_pc;
  logic [15:0] dbg_a;
  logic [15:0] dbg_sw;
  logic        mready_drv;
  logic [15:0] mem [0:4095];

  int vectors     = 0;
  int miscompares = 0;

  int          wr_count = 0;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;

  mcu0_if #(.DW(16), .AW(12)) bus ();

  mcu0_core #(.DW(16), .AW(12), .INC(2), .RST_PC(0)) dut (
    .clock  (clock),
    .reset  (reset),
    .mbus   (bus),
    .halted (halted),
    .dbg_pc (dbg_pc),
    .dbg_a  (dbg_a),
    .dbg_sw (dbg_sw)
  );

  always #5 clock = ~clock;

  assign bus.mready = mready_drv;
  assign bus.mrdata = mem[bus.maddr];

  always @(posedge clock) begin
    if (bus.men && bus.mw && bus.mready) begin
      wr_count <= wr_count + 1;
      wr_addr  <= bus.maddr;
      wr_data  <= bus.mwdata;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1);
  end

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] c);
    return {op, c};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'hF000;
  endtask

  // Reset for two cycles, release on a falling edge.
  task automatic start();
    reset      = 1'b0;
    mready_drv = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Wait for the next transaction to be raised (men rising); bounded.
  task automatic next_req(output logic [11:0] ad, output logic w, output bit ok);
    logic prev;
    prev = bus.men;
    ok   = 1'b0;
    ad   = '0;
    w    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.men && !prev) begin
        ad = bus.maddr;
        w  = bus.mw;
        ok = 1'b1;
        return;
      end
      prev = bus.men;
    end
  endtask

  task automatic run_to_fetch(input logic [11:0] target, output bit ok);
    logic [11:0] ad;
    logic        w;
    bit          got;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next_req(ad, w, got);
      if (!got) return;
      if (!w && ad == target) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    reset      = 1'b0;
    mready_drv = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (bus.men !== 1'b0) begin miscompares++; $display("FAIL reset_men: got %b want 0", bus.men); end
    vectors++;
    if (bus.mw !== 1'b0) begin miscompares++; $display("FAIL reset_mw: got %b want 0", bus.mw); end
    vectors++;
    if (dbg_pc !== 12'h000) begin miscompares++; $display("FAIL reset_pc: got %h want 000", dbg_pc); end
    vectors++;
    if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
    vectors++;
    if (dbg_a !== 16'h0000 || dbg_sw !== 16'h0000) begin
      miscompares++; $display("FAIL reset_a_sw: got a=%h sw=%h want 0000/0000", dbg_a, dbg_sw);
    end
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (bus.men !== 1'b1 || bus.mw !== 1'b0 || bus.maddr !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_first_fetch: got men=%b mw=%b maddr=%h want 1/0/000", bus.men, bus.mw, bus.maddr);
    end
  endtask

  task automatic test_ld_add_st();
    int early;
    int base;
    clear_mem();
    mem[12'h000] = ins(4'h0, 12'h100);
    mem[12'h002] = ins(4'h1, 12'h102);
    mem[12'h004] = ins(4'h3, 12'h104);
    mem[12'h100] = 16'h0003;
    mem[12'h102] = 16'h0004;
    start();
    base  = wr_count;
    early = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (bus.men && bus.mw) early++;
    end
    vectors++;
    if (early !== 0) begin miscompares++; $display("FAIL st_early_write: got %0d write cycles want 0", early); end
    @(negedge clock);
    vectors++;
    if (bus.men !== 1'b1 || bus.mw !== 1'b1 || bus.maddr !== 12'h104 || bus.mwdata !== 16'h0007) begin
      miscompares++;
      $display("FAIL st_write: got men=%b mw=%b maddr=%h mwdata=%h want 1/1/104/0007",
               bus.men, bus.mw, bus.maddr, bus.mwdata);
    end
    vectors++;
    if (dbg_sw !== 16'h0000 || dbg_a !== 16'h0007) begin
      miscompares++; $display("FAIL st_regs: got a=%h sw=%h want 0007/0000", dbg_a, dbg_sw);
    end
    @(negedge clock);
    vectors++;
    if (wr_count !== base + 1 || wr_addr !== 12'h104 || wr_data !== 16'h0007 || bus.men !== 1'b0) begin
      miscompares++;
      $display("FAIL st_accept: got writes=%0d addr=%h data=%h men=%b want %0d/104/0007/0",
               wr_count - base, wr_addr, wr_data, bus.men, 1);
    end
  endtask

  // Continues from the LD/ADD/ST program, whose next word is HLT.
  task automatic test_halt();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (halted) seen = 1'b1;
    end
    vectors++;
    if (!seen || dbg_pc !== 12'h008) begin
      miscompares++; $display("FAIL halt_enter: got halted=%b pc=%h want 1/008", halted, dbg_pc);
    end
    for (int i = 0; i < 20; i++) begin
      mready_drv = i[0];
      @(negedge clock);
      vectors++;
      if (bus.men !== 1'b0 || halted !== 1'b1) begin
        miscompares++; $display("FAIL halt_hold cycle %0d: got men=%b halted=%b want 0/1", i, bus.men, halted);
      end
    end
    mready_drv = 1'b1;
  endtask

  task automatic test_wait_states();
    bit found;
    clear_mem();
    mem[12'h000] = ins(4'h8, 12'h005);
    mem[12'h002] = ins(4'h8, 12'h009);
    start();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (bus.men && bus.maddr == 12'h002) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL ws_request: got no fetch of 002 want one"); end
    mready_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (bus.men !== 1'b1 || bus.maddr !== 12'h002 || dbg_pc !== 12'h002) begin
        miscompares++;
        $display("FAIL ws_stall %0d: got men=%b maddr=%h pc=%h want 1/002/002", i, bus.men, bus.maddr, dbg_pc);
      end
    end
    mready_drv = 1'b1;
    @(negedge clock);
    vectors++;
    if (bus.men !== 1'b0 || dbg_pc !== 12'h004) begin
      miscompares++; $display("FAIL ws_accept: got men=%b pc=%h want 0/004", bus.men, dbg_pc);
    end
    @(negedge clock);
    vectors++;
    if (dbg_a !== 16'h0009) begin miscompares++; $display("FAIL ws_exec: got a=%h want 0009", dbg_a); end
  endtask

  task automatic test_branch();
    logic [11:0] ad;
    logic        w;
    bit          ok;
    clear_mem();
    mem[12'h000] = ins(4'h8, 12'h005);
    mem[12'h002] = ins(4'h4, 12'h200);
    mem[12'h004] = ins(4'h5, 12'h020);
    mem[12'h020] = ins(4'h4, 12'h202);
    mem[12'h022] = ins(4'h5, 12'h030);
    mem[12'h024] = ins(4'h7, 12'h040);
    mem[12'h200] = 16'h0005;
    mem[12'h202] = 16'h0006;
    start();
    run_to_fetch(12'h004, ok);
    vectors++;
    if (!ok || dbg_a !== 16'h0005 || dbg_sw !== 16'h4000) begin
      miscompares++; $display("FAIL cmp_eq: got ok=%b a=%h sw=%h want 1/0005/4000", ok, dbg_a, dbg_sw);
    end
    next_req(ad, w, ok);
    vectors++;
    if (!ok || w !== 1'b0 || ad !== 12'h020) begin
      miscompares++; $display("FAIL jeq_taken: got ok=%b mw=%b maddr=%h want 1/0/020", ok, w, ad);
    end
    run_to_fetch(12'h022, ok);
    vectors++;
    if (!ok || dbg_sw !== 16'h8000) begin
      miscompares++; $display("FAIL cmp_lt: got ok=%b sw=%h want 1/8000", ok, dbg_sw);
    end
    next_req(ad, w, ok);
    vectors++;
    if (!ok || w !== 1'b0 || ad !== 12'h024) begin
      miscompares++; $display("FAIL jeq_not_taken: got ok=%b mw=%b maddr=%h want 1/0/024", ok, w, ad);
    end
    next_req(ad, w, ok);
    vectors++;
    if (!ok || w !== 1'b0 || ad !== 12'h040) begin
      miscompares++; $display("FAIL jlt_taken: got ok=%b mw=%b maddr=%h want 1/0/040", ok, w, ad);
    end
  endtask

  task automatic test_arith();
    logic [11:0] tgt  [6] = '{12'h004, 12'h006, 12'h008, 12'h00C, 12'h00E, 12'h010};
    logic [15:0] exp_a[6] = '{16'hFFFF, 16'h0FFF, 16'h1FFE, 16'h0000, 16'h8001, 16'h4000};
    logic [15:0] exp_s[6] = '{16'hA000, 16'h2000, 16'h0000, 16'h6000, 16'hA000, 16'h2000};
    bit ok;
    clear_mem();
    mem[12'h000] = ins(4'h8, 12'h000);
    mem[12'h002] = ins(4'h6, 12'h200);
    mem[12'h004] = ins(4'h8, 12'hFFF);
    mem[12'h006] = ins(4'hC, 12'h000);
    mem[12'h008] = ins(4'h8, 12'hFFF);
    mem[12'h00A] = ins(4'h1, 12'h202);
    mem[12'h00C] = ins(4'hB, 12'h204);
    mem[12'h00E] = ins(4'hD, 12'h000);
    mem[12'h200] = 16'h0001;
    mem[12'h202] = 16'hF001;
    mem[12'h204] = 16'h8001;
    start();
    for (int i = 0; i < 6; i++) begin
      run_to_fetch(tgt[i], ok);
      vectors++;
      if (!ok || dbg_a !== exp_a[i] || dbg_sw !== exp_s[i]) begin
        miscompares++;
        $display("FAIL arith step %0d: got ok=%b a=%h sw=%h want 1/%h/%h", i, ok, dbg_a, dbg_sw, exp_a[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [11:0] ad;
    logic        w;
    bit          ok;
    clear_mem();
    mem[12'h000] = ins(4'h2, 12'hFFE);
    mem[12'hFFE] = ins(4'hE, 12'h000);
    start();
    run_to_fetch(12'hFFE, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL wrap_jmp: got no fetch of FFE want one"); end
    next_req(ad, w, ok);
    vectors++;
    if (!ok || ad !== 12'h000 || dbg_pc !== 12'h000) begin
      miscompares++; $display("FAIL wrap_pc: got ok=%b maddr=%h pc=%h want 1/000/000", ok, ad, dbg_pc);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] ad;
    logic        w;
    bit          ok;
    clear_mem();
    mem[12'h000] = ins(4'h0, 12'h100);
    start();
    next_req(ad, w, ok);
    next_req(ad, w, ok);
    mready_drv = 1'b0;
    vectors++;
    if (!ok || w !== 1'b0 || ad !== 12'h100) begin
      miscompares++; $display("FAIL rmid_read: got ok=%b mw=%b maddr=%h want 1/0/100", ok, w, ad);
    end
    repeat (2) @(negedge clock);
    vectors++;
    if (bus.men !== 1'b1) begin miscompares++; $display("FAIL rmid_stall: got men=%b want 1", bus.men); end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (bus.men !== 1'b0 || bus.maddr !== 12'h000) begin
      miscompares++; $display("FAIL rmid_async: got men=%b maddr=%h want 0/000", bus.men, bus.maddr);
    end
    mready_drv = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (bus.men !== 1'b1 || bus.mw !== 1'b0 || bus.maddr !== 12'h000) begin
      miscompares++;
      $display("FAIL rmid_restart: got men=%b mw=%b maddr=%h want 1/0/000", bus.men, bus.mw, bus.maddr);
    end
  endtask

  initial begin
    reset      = 1'b0;
    mready_drv = 1'b1;
    test_reset();
    test_ld_add_st();
    test_halt();
    test_wait_states();
    test_branch();
    test_arith();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
